// File: rtl/exe_shift_stage_pkg.sv
// Shared types for the RV32 execute-stage shift slot: command encoding,
// register-index width and the per-op result bundle carried through the stage.
package exe_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;

  typedef enum logic [2:0] {
    SHIFT_SLL = 3'b001,
    SHIFT_SRL = 3'b010,
    SHIFT_SRA = 3'b100
  } shift_cmd_e;

  // Everything the memory stage sees for one op travels as a single word so
  // fields from different ops can never be paired up.
  typedef struct packed {
    logic [XLEN-1:0]      result;
    logic [REG_IDX_W-1:0] rd;
    logic                 illegal;
  } exe_entry_t;

endpackage

// File: rtl/exe_shift_stage_shifter.sv
// Combinational barrel shifter for SLL/SRL/SRA; any non-one-hot command
// yields a zero result and raises illegal.
module shifter_unit
  import exe_pkg::*;
#(
  parameter int unsigned W = XLEN
) (
  input  logic [W-1:0]         op,
  input  logic [$clog2(W)-1:0] shamt,
  input  logic [2:0]           cmd,
  output logic [W-1:0]         result,
  output logic                 illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    result  = '0;
    illegal = 1'b0;
    case (cmd)
      SHIFT_SLL: result = op << shamt;
      SHIFT_SRL: result = op >> shamt;
      SHIFT_SRA: result = $signed(op) >>> shamt;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/exe_shift_stage.sv
// Execute-stage shift slot: valid/ready in from decode, registered result out
// to memory. Define EXE_SKID_EN for a two-entry skid buffer with registered ready.
module exe_shift_stage
  import exe_pkg::*;
#(
  parameter int unsigned bitWidth = XLEN
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush_i,
  input  logic                 dec2exe_valid_i,
  output logic                 dec2exe_ready_o,
  input  logic [bitWidth-1:0]  op1_i,
  input  logic [bitWidth-1:0]  op2_i,
  input  logic [2:0]           cmd_i,
  input  logic [REG_IDX_W-1:0] rd_i,
  output logic                 exe2mem_valid_o,
  input  logic                 exe2mem_ready_i,
  output logic [bitWidth-1:0]  result_o,
  output logic [REG_IDX_W-1:0] rd_o,
  output logic                 illegal_o
);

  localparam int unsigned SHAMT_W = $clog2(bitWidth);

  logic [bitWidth-1:0] sh_result;
  logic                sh_illegal;
  exe_entry_t          in_entry;
  exe_entry_t          main_q;
  logic                main_valid_q;
  logic                accept;
  logic                out_xfer;
  logic                unused_op2_hi;

  // Only the low shamt bits select the distance; the rest are architecturally ignored.
  assign unused_op2_hi = ^op2_i[bitWidth-1:SHAMT_W];

  shifter_unit #(.W(bitWidth)) u_shifter (
    .op      (op1_i),
    .shamt   (op2_i[SHAMT_W-1:0]),
    .cmd     (cmd_i),
    .result  (sh_result),
    .illegal (sh_illegal)
  );

  assign in_entry = '{result: sh_result, rd: rd_i, illegal: sh_illegal};

  assign accept   = dec2exe_valid_i && dec2exe_ready_o && !flush_i;
  assign out_xfer = main_valid_q && exe2mem_ready_i;

  assign exe2mem_valid_o = main_valid_q;
  assign result_o        = main_q.result;
  assign rd_o            = main_q.rd;
  assign illegal_o       = main_q.illegal;

`ifdef EXE_SKID_EN
  exe_entry_t skid_q;
  logic       skid_valid_q;

  // Ready comes straight from a flop, so it cannot see this cycle's stall;
  // the skid slot catches the one op that may arrive after main stalls.
  assign dec2exe_ready_o = !skid_valid_q;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: the data registers are reset as well, because the outputs
      // must read zero after reset, not just be marked invalid.
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else if (flush_i) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!main_valid_q || out_xfer) begin
      if (skid_valid_q) begin
        main_q       <= skid_q;
        main_valid_q <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        main_q       <= in_entry;
        main_valid_q <= 1'b1;
      end else begin
        main_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_q       <= in_entry;
      skid_valid_q <= 1'b1;
    end
  end
`else
  assign dec2exe_ready_o = !main_valid_q || exe2mem_ready_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_q       <= '0;
    end else if (flush_i) begin
      main_valid_q <= 1'b0;
    end else if (accept) begin
      main_q       <= in_entry;
      main_valid_q <= 1'b1;
    end else if (out_xfer) begin
      main_valid_q <= 1'b0;
    end
  end
`endif

endmodule
